// File: rtl/tx_framer_pkg.sv
// Shared types and constants for the RMII transmit framer and its CRC helper.
package tx_framer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    PAD,
    FCS,
    IFG
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] dibit;
  } dl_entry_t;

  localparam int          PREAMBLE_DIBITS = 31;
  localparam logic [1:0]  SFD_DIBIT       = 2'b11;
  localparam logic [1:0]  PREAMBLE_DIBIT  = 2'b01;
  localparam logic [31:0] CRC_POLY        = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;
  localparam int          DELAY_DEPTH     = 32;
  localparam int          FCS_DIBITS      = 16;
  localparam int          CNT_W           = 12;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/crc32_dibit.sv
// Combinational reflected CRC-32 step over one dibit, bit [0] first.
module crc32_dibit
  import tx_framer_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [1:0]  dibit,
  output logic [31:0] crc_out
);

  logic [2:0][31:0] stage;

  assign stage[0] = crc_in;

  for (genvar gi = 0; gi < 2; gi++) begin : g_bit
    assign stage[gi+1] = (stage[gi] >> 1) ^ ({32{stage[gi][0] ^ dibit[gi]}} & CRC_POLY);
  end

  assign crc_out = stage[2];

endmodule

// File: rtl/tx_framer.sv
// RMII transmit framer: preamble/SFD, 33-cycle delayed payload, optional
// minimum-length padding (TX_FRAMER_PAD_EN), FCS, then inter-frame gap.
module tx_framer
  import tx_framer_pkg::*;
#(
  parameter int IFG_CYCLES      = 48,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  output logic       axiov,
  output logic [1:0] axiod
);

  localparam int STEP_W = 16;
  localparam logic [CNT_W-1:0] MIN_PAD_DIBITS = CNT_W'(MIN_FRAME_BYTES * 4);

  state_t                        state_reg, state_next;
  logic                          armed_reg, armed_next;
  logic [STEP_W-1:0]             step_reg, step_next;
  logic [CNT_W-1:0]              cnt_reg, cnt_next;
  logic [31:0]                   crc_reg, crc_next;
  logic [31:0]                   fcs_reg, fcs_next;
  logic                          axiov_reg, axiov_next;
  logic [1:0]                    axiod_reg, axiod_next;
  dl_entry_t [DELAY_DEPTH-1:0]   dl_reg;

  dl_entry_t   dl_head;
  logic        start;
  logic        pad_go;
  logic [1:0]  crc_din;
  logic [31:0] crc_step;
  logic [31:0] fcs_now;

  assign dl_head = dl_reg[DELAY_DEPTH-1];
  assign start   = (state_reg == IDLE) && axiiv && armed_reg;
  assign crc_din = dl_head.valid ? dl_head.dibit : 2'b00;
  assign fcs_now = ~crc_reg;

`ifdef TX_FRAMER_PAD_EN
  logic pad_done;
  assign pad_go   = (cnt_reg < MIN_PAD_DIBITS);
  assign pad_done = (cnt_reg == MIN_PAD_DIBITS);
`else
  logic unused_pad_cfg;
  assign pad_go         = 1'b0;
  assign unused_pad_cfg = ^MIN_PAD_DIBITS;
`endif

  crc32_dibit u_crc (
    .crc_in  (crc_reg),
    .dibit   (crc_din),
    .crc_out (crc_step)
  );

  // The delay line shifts every cycle; only the head is read, and only in DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_reg    <= '0;
      state_reg <= IDLE;
      armed_reg <= 1'b0;
      step_reg  <= '0;
      cnt_reg   <= '0;
      crc_reg   <= CRC_INIT;
      fcs_reg   <= '0;
      axiov_reg <= 1'b0;
      axiod_reg <= 2'b00;
    end else begin
      dl_reg    <= {dl_reg[DELAY_DEPTH-2:0], dl_entry_t'({axiiv, axiid})};
      state_reg <= state_next;
      armed_reg <= armed_next;
      step_reg  <= step_next;
      cnt_reg   <= cnt_next;
      crc_reg   <= crc_next;
      fcs_reg   <= fcs_next;
      axiov_reg <= axiov_next;
      axiod_reg <= axiod_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg + 1'b1;
    cnt_next   = cnt_reg;
    crc_next   = crc_reg;
    fcs_next   = fcs_reg;

    // A rising valid outside IDLE is a missed start: stay disarmed until it drops.
    armed_next = armed_reg;
    if (start)
      armed_next = 1'b0;
    else if (!axiiv)
      armed_next = 1'b1;
    else if (state_reg != IDLE)
      armed_next = 1'b0;

    case (state_reg)
      IDLE: begin
        step_next = '0;
        if (start) begin
          state_next = PREAMBLE;
          step_next  = STEP_W'(1);
          cnt_next   = '0;
          crc_next   = CRC_INIT;
        end
      end
      PREAMBLE: begin
        if (step_reg == STEP_W'(PREAMBLE_DIBITS)) begin
          state_next = DATA;
          step_next  = '0;
        end
      end
      DATA: begin
        if (dl_head.valid || pad_go) begin
          crc_next = crc_step;
          cnt_next = sat_inc(cnt_reg);
          if (!dl_head.valid)
            state_next = PAD;
        end else begin
          state_next = FCS;
          fcs_next   = fcs_now >> 2;
          step_next  = STEP_W'(1);
        end
      end
`ifdef TX_FRAMER_PAD_EN
      PAD: begin
        if (pad_done) begin
          state_next = FCS;
          fcs_next   = fcs_now >> 2;
          step_next  = STEP_W'(1);
        end else begin
          crc_next = crc_step;
          cnt_next = sat_inc(cnt_reg);
        end
      end
`endif
      FCS: begin
        fcs_next = fcs_reg >> 2;
        if (step_reg == STEP_W'(FCS_DIBITS - 1)) begin
          state_next = IFG;
          step_next  = '0;
        end
      end
      IFG: begin
        if (step_reg == STEP_W'(IFG_CYCLES - 1)) begin
          state_next = IDLE;
          step_next  = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values for the registered TX_EN/TXD pins; the first FCS dibit goes
  // out on the same edge the payload end is detected.
  always_comb begin
    axiov_next = 1'b0;
    axiod_next = 2'b00;
    case (state_reg)
      IDLE: begin
        if (start) begin
          axiov_next = 1'b1;
          axiod_next = PREAMBLE_DIBIT;
        end
      end
      PREAMBLE: begin
        axiov_next = 1'b1;
        axiod_next = (step_reg == STEP_W'(PREAMBLE_DIBITS)) ? SFD_DIBIT : PREAMBLE_DIBIT;
      end
      DATA: begin
        axiov_next = 1'b1;
        if (dl_head.valid)
          axiod_next = dl_head.dibit;
        else if (pad_go)
          axiod_next = 2'b00;
        else
          axiod_next = fcs_now[1:0];
      end
`ifdef TX_FRAMER_PAD_EN
      PAD: begin
        axiov_next = 1'b1;
        axiod_next = pad_done ? fcs_now[1:0] : 2'b00;
      end
`endif
      FCS: begin
        axiov_next = 1'b1;
        axiod_next = fcs_reg[1:0];
      end
      default: begin
        axiov_next = 1'b0;
        axiod_next = 2'b00;
      end
    endcase
  end

  assign axiov = axiov_reg;
  assign axiod = axiod_reg;

endmodule

// File: tb/tb_tx_framer.sv
// Self-checking bench for tx_framer: table of frames plus hand-written
// back-to-back, reset and gap sequences, scored against an expected-dibit queue.
module tb_tx_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic       axiiv;
  logic [1:0] axiid;
  logic       axiov;
  logic [1:0] axiod;

  always #10 clk = ~clk;

  tx_framer dut (
    .clk   (clk),
    .rst   (rst),
    .axiiv (axiiv),
    .axiid (axiid),
    .axiov (axiov),
    .axiod (axiod)
  );

`ifdef TX_FRAMER_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif
  localparam int MIN_DIBITS = 240;
  localparam int GAP_WAIT   = 60;

  typedef struct {
    string       name;
    int          kind;      // 0: "123456789", 1: random bytes, 2: incrementing bytes
    int          nbytes;
    int          exp_len;   // cycles with axiov high
    bit          use_const;
    logic [31:0] exp_fcs;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          rise_cyc = 0;
  int          on_cyc = 0;
  int          off_cyc = 0;
  int          falls = 0;
  bit          rise_arm = 1'b0;
  bit          mon_en = 1'b0;
  logic        axiov_prev = 1'b0;
  logic [31:0] cap_fcs = '0;
  logic [31:0] model_fcs = '0;
  logic [1:0]  pay[$];
  logic [1:0]  exp_q[$];

  function automatic logic [31:0] crc_model(input logic [31:0] c_in, input logic [1:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int b = 0; b < 2; b++) begin
      fb = c[0] ^ d[b];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (rise_arm && axiiv === 1'b1) begin
        rise_cyc = cyc;
        rise_arm = 1'b0;
      end
      if (axiov === 1'b1) begin
        if (axiov_prev !== 1'b1) on_cyc = cyc;
        cap_fcs = {axiod, cap_fcs[31:2]};
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_axiov: axiov=1 axiod=%b at cycle %0d, required axiov=0", axiod, cyc);
        end else begin
          check("dibit", 32'(axiod), 32'(exp_q.pop_front()));
        end
      end else begin
        check("idle_axiod", 32'(axiod), 32'd0);
        if (axiov_prev === 1'b1) begin
          off_cyc = cyc;
          falls++;
        end
      end
      axiov_prev = axiov;
    end
  end

  task automatic add_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) pay.push_back(b[2*k +: 2]);
  endtask

  task automatic add_random(input int n);
    for (int i = 0; i < n; i++) add_byte(8'($urandom_range(0, 255)));
  endtask

  task automatic push_preamble(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(i < 31 ? 2'b01 : 2'b11);
  endtask

  // Expected wire stream for the first ndata payload dibits.
  task automatic push_expected(input int ndata);
    logic [31:0] c;
    int          n;
    c = 32'hFFFFFFFF;
    push_preamble(32);
    for (int i = 0; i < ndata; i++) begin
      exp_q.push_back(pay[i]);
      c = crc_model(c, pay[i]);
    end
    n = ndata;
    if (PAD_ON) begin
      while (n < MIN_DIBITS) begin
        exp_q.push_back(2'b00);
        c = crc_model(c, 2'b00);
        n++;
      end
    end
    model_fcs = ~c;
    for (int k = 0; k < 16; k++) exp_q.push_back(model_fcs[2*k +: 2]);
  endtask

  task automatic drive(input int gap_at, input int reset_at);
    for (int i = 0; i < pay.size(); i++) begin
      @(posedge clk);
      #1;
      rst = (i == reset_at);
      if (i == gap_at) begin
        axiiv = 1'b0;
        axiid = 2'b00;
      end else begin
        axiiv = 1'b1;
        axiid = pay[i];
      end
    end
    @(posedge clk);
    #1;
    axiiv = 1'b0;
    axiid = 2'b00;
    rst   = 1'b0;
  endtask

  task automatic wait_fall(input string name, input int f0, input int budget);
    int k;
    k = 0;
    while (falls == f0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (falls == f0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: axiov did not fall within %0d cycles", name, budget);
    end
  endtask

  task automatic send_and_check(input string name, input int exp_len,
                                input bit use_const, input logic [31:0] const_fcs);
    int f0;
    exp_q.delete();
    push_expected(pay.size());
    f0 = falls;
    rise_arm = 1'b1;
    drive(-1, -1);
    wait_fall(name, f0, 3000);
    check({name, "_on_cycle"}, 32'(on_cyc - rise_cyc), 32'd1);
    check({name, "_off_cycle"}, 32'(off_cyc - rise_cyc), 32'(exp_len + 1));
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_fcs"}, cap_fcs, use_const ? const_fcs : model_fcs);
    $display("frame %s: dibits=%0d axiov_cycles=%0d fcs=0x%08h", name, pay.size(), off_cyc - on_cyc, cap_fcs);
    repeat (GAP_WAIT) @(posedge clk);
  endtask

  function automatic int frame_len(input int nbytes);
    int d;
    d = nbytes * 4;
    if (PAD_ON && d < MIN_DIBITS) d = MIN_DIBITS;
    return 32 + d + 16;
  endfunction

  initial begin
    vec_t tbl[5];
    int   f0;
    int   f1;

    tbl[0] = '{"crc_check", 0, 9,  PAD_ON ? 288 : 84,  !PAD_ON, 32'hCBF43926};
    tbl[1] = '{"rand64",    1, 64, 304,                1'b0,    32'h0};
    tbl[2] = '{"one_byte",  2, 1,  PAD_ON ? 288 : 52,  1'b0,    32'h0};
    tbl[3] = '{"min60",     1, 60, 288,                1'b0,    32'h0};
    tbl[4] = '{"rand59",    1, 59, PAD_ON ? 288 : 284, 1'b0,    32'h0};

    rst   = 1'b1;
    axiiv = 1'b0;
    axiid = 2'b00;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset: monitor checks axiov/axiod every cycle.
    repeat (100) @(posedge clk);
    check("idle_no_frames", 32'(falls), 32'd0);

    for (int i = 0; i < 5; i++) begin
      pay.delete();
      for (int b = 0; b < tbl[i].nbytes; b++) begin
        case (tbl[i].kind)
          0:       add_byte(8'h31 + 8'(b));
          2:       add_byte(8'hA5 + 8'(b));
          default: add_byte(8'($urandom_range(0, 255)));
        endcase
      end
      send_and_check(tbl[i].name, tbl[i].exp_len, tbl[i].use_const, tbl[i].exp_fcs);
    end

    // Back-to-back: frame B lands inside the IFG and must be ignored.
    pay.delete();
    add_random(16);
    exp_q.delete();
    push_expected(pay.size());
    f0 = falls;
    rise_arm = 1'b1;
    drive(-1, -1);
    wait_fall("b2b_a", f0, 3000);
    check("b2b_a_off_cycle", 32'(off_cyc - rise_cyc), 32'(frame_len(16) + 1));
    repeat (10) @(posedge clk);
    pay.delete();
    add_random(8);
    exp_q.delete();
    f1 = falls;
    drive(-1, -1);
    repeat (GAP_WAIT) @(posedge clk);
    check("b2b_b_ignored", 32'(falls), 32'(f1));
    pay.delete();
    add_random(10);
    send_and_check("b2b_c", frame_len(10), 1'b0, 32'h0);

    // Reset at cycle 40 with axiiv held high afterwards.
    pay.delete();
    add_random(20);
    exp_q.delete();
    push_preamble(32);
    for (int i = 0; i < 8; i++) exp_q.push_back(pay[i]);
    f0 = falls;
    rise_arm = 1'b1;
    drive(-1, 40);
    wait_fall("rst", f0, 3000);
    check("rst_off_cycle", 32'(off_cyc - rise_cyc), 32'd41);
    check("rst_drained", 32'(exp_q.size()), 32'd0);
    repeat (GAP_WAIT) @(posedge clk);
    check("rst_no_restart", 32'(falls), 32'(f0 + 1));
    pay.delete();
    add_random(12);
    send_and_check("after_rst", frame_len(12), 1'b0, 32'h0);

    // One-cycle gap at dibit 20; resumed dibits run past the IFG and are dropped.
    pay.delete();
    add_random(5);
    add_random(101);
    exp_q.delete();
    push_expected(20);
    f0 = falls;
    rise_arm = 1'b1;
    drive(20, -1);
    wait_fall("gap", f0, 3000);
    check("gap_off_cycle", 32'(off_cyc - rise_cyc), 32'(frame_len(5) + 1));
    check("gap_drained", 32'(exp_q.size()), 32'd0);
    check("gap_fcs", cap_fcs, model_fcs);
    repeat (GAP_WAIT) @(posedge clk);
    check("gap_no_restart", 32'(falls), 32'(f0 + 1));
    pay.delete();
    add_random(7);
    send_and_check("after_gap", frame_len(7), 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
